// File: rtl/wb_interconnect_1xn_tmo.sv
// Single-master to N-slave Wishbone interconnect with address decode, cycle locking
// and a wait-state watchdog that terminates stalled accesses with an error.
module wb_interconnect_1xn_tmo #(
   parameter int WB_ADDR_WIDTH  = 32,
   parameter int WB_DATA_WIDTH  = 32,
   parameter int N_SLAVES       = 4,
   parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE  = '0,
   parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_LIMIT = '0,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [WB_ADDR_WIDTH-1:0]        m_adr,
   input  logic [WB_DATA_WIDTH-1:0]        m_dat_w,
   input  logic [WB_DATA_WIDTH/8-1:0]      m_sel,
   input  logic [2:0]                      m_cti,
   input  logic [1:0]                      m_bte,
   input  logic                            m_we,
   input  logic                            m_cyc,
   input  logic                            m_stb,
   output logic [WB_DATA_WIDTH-1:0]        m_dat_r,
   output logic                            m_ack,
   output logic                            m_err,
   output logic [WB_ADDR_WIDTH-1:0]        s_adr,
   output logic [WB_DATA_WIDTH-1:0]        s_dat_w,
   output logic [WB_DATA_WIDTH/8-1:0]      s_sel,
   output logic [2:0]                      s_cti,
   output logic [1:0]                      s_bte,
   output logic                            s_we,
   output logic [N_SLAVES-1:0]             s_cyc,
   output logic [N_SLAVES-1:0]             s_stb,
   input  logic [N_SLAVES*WB_DATA_WIDTH-1:0] s_dat_r,
   input  logic [N_SLAVES-1:0]             s_ack,
   input  logic [N_SLAVES-1:0]             s_err,
   output logic                            tmo_pulse,
   output logic                            busy
);

   localparam int AW  = WB_ADDR_WIDTH;
   localparam int DW  = WB_DATA_WIDTH;
   localparam int SW  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int WCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ERR_RESP} state_t;

   state_t           state_q, state_d;
   logic [SW-1:0]    sel_q, sel_d;
   logic [WCW-1:0]   wcnt_q, wcnt_d;
   logic             tmo_q, tmo_d;

   logic [N_SLAVES-1:0] match;
   logic [N_SLAVES-1:0] sel_oh;
   logic                hit;
   logic [SW-1:0]       hit_idx;
   logic                sel_valid;
   logic                sel_ack;
   logic                sel_err;
   logic [DW-1:0]       sel_dat;

   assign s_adr   = m_adr;
   assign s_dat_w = m_dat_w;
   assign s_sel   = m_sel;
   assign s_cti   = m_cti;
   assign s_bte   = m_bte;
   assign s_we    = m_we;

   for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slave
      assign match[gi]  = (m_adr >= SLAVE_BASE[gi*AW +: AW]) && (m_adr <= SLAVE_LIMIT[gi*AW +: AW]);
      assign sel_oh[gi] = (sel_q == SW'(gi));
   end

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit     = 1'b1;
            hit_idx = SW'(i);
         end
      end
   end

   // One-hot AND-OR mux keeps out-of-range sel_q encodings from selecting anything.
   always_comb begin
      sel_dat = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         sel_dat = sel_dat | (s_dat_r[i*DW +: DW] & {DW{sel_oh[i]}});
      end
   end

   assign sel_valid = |sel_oh;
   assign sel_ack   = |(s_ack & sel_oh);
   assign sel_err   = |(s_err & sel_oh);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      wcnt_d  = wcnt_q;
      tmo_d   = 1'b0;
      s_cyc   = '0;
      s_stb   = '0;
      m_ack   = 1'b0;
      m_err   = 1'b0;
      m_dat_r = '0;
      case (state_q)
         ST_IDLE: begin
            if (m_cyc && m_stb) begin
               if (hit) begin
                  sel_d   = hit_idx;
                  wcnt_d  = '0;
                  state_d = ST_ACTIVE;
               end else begin
                  state_d = ST_ERR_RESP;
               end
            end
         end
         ST_ACTIVE: begin
            if (!sel_valid) begin
               state_d = ST_ERR_RESP;
            end else begin
               s_cyc   = sel_oh & {N_SLAVES{m_cyc}};
               s_stb   = sel_oh & {N_SLAVES{m_stb}};
               m_err   = sel_err & m_stb;
               m_ack   = sel_ack & ~sel_err & m_stb;
               m_dat_r = sel_dat;
               if (!m_cyc) begin
                  state_d = ST_IDLE;
               end else if (m_ack || m_err) begin
                  wcnt_d = '0;
               end else if (m_stb && (TIMEOUT_CYCLES > 0)) begin
                  if (wcnt_q == WCW'(TIMEOUT_CYCLES - 1)) begin
                     state_d = ST_ERR_RESP;
                     tmo_d   = 1'b1;
                  end else begin
                     wcnt_d = wcnt_q + 1'b1;
                  end
               end
            end
         end
         ST_ERR_RESP: begin
            m_err   = 1'b1;
            wcnt_d  = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         wcnt_q  <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         wcnt_q  <= wcnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign tmo_pulse = tmo_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_interconnect_1xn_tmo.sv
// Directed bench for wb_interconnect_1xn_tmo: decode, wait states, unmapped error,
// timeout, overlapping ranges with burst locking, dual response and async reset.
module tb_wb_interconnect_1xn_tmo;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int N  = 4;
   // slave0 0x3000-0x3FFF, slave1 0x0-0xFFF, slave2 0x2000-0x2FFF, slave3 0x800-0x1FFF
   localparam logic [N*AW-1:0] BASE  = {32'h0000_0800, 32'h0000_2000, 32'h0000_0000, 32'h0000_3000};
   localparam logic [N*AW-1:0] LIMIT = {32'h0000_1FFF, 32'h0000_2FFF, 32'h0000_0FFF, 32'h0000_3FFF};

   logic            clk;
   logic            rst;
   logic [AW-1:0]   m_adr;
   logic [DW-1:0]   m_dat_w;
   logic [DW/8-1:0] m_sel;
   logic [2:0]      m_cti;
   logic [1:0]      m_bte;
   logic            m_we, m_cyc, m_stb;
   logic [DW-1:0]   m_dat_r;
   logic            m_ack, m_err;
   logic [AW-1:0]   s_adr;
   logic [DW-1:0]   s_dat_w;
   logic [DW/8-1:0] s_sel;
   logic [2:0]      s_cti;
   logic [1:0]      s_bte;
   logic            s_we;
   logic [N-1:0]    s_cyc, s_stb;
   logic [N*DW-1:0] s_dat_r;
   logic [N-1:0]    s_ack, s_err;
   logic            tmo_pulse, busy;

   int n_assert = 0;
   int n_fail   = 0;
   int acks;
   logic [N-1:0] stb_seen;

   wb_interconnect_1xn_tmo #(
      .WB_ADDR_WIDTH (AW),
      .WB_DATA_WIDTH (DW),
      .N_SLAVES      (N),
      .SLAVE_BASE    (BASE),
      .SLAVE_LIMIT   (LIMIT),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
      .m_we(m_we), .m_cyc(m_cyc), .m_stb(m_stb),
      .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
      .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
      .s_we(s_we), .s_cyc(s_cyc), .s_stb(s_stb),
      .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
      .tmo_pulse(tmo_pulse), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
      stb_seen = stb_seen | s_stb;
   endtask

   task automatic idle_bus();
      m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_cti = 3'b000;
      s_ack = '0;   s_err = '0;
   endtask

   task automatic req(input logic [AW-1:0] adr, input logic we);
      m_adr = adr; m_we = we; m_cyc = 1'b1; m_stb = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      m_adr = 32'h0000_1234; m_dat_w = '0; m_sel = 4'hF; m_bte = 2'b00;
      s_dat_r = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
      idle_bus();
      stb_seen = '0;
      #2;
      chk("rst_busy", busy, 1'b0);
      chk("rst_s_stb", s_stb, 4'h0);
      chk("rst_s_cyc", s_cyc, 4'h0);
      chk("rst_m_ack", m_ack, 1'b0);
      chk("rst_m_err", m_err, 1'b0);
      chk("rst_m_dat_r", m_dat_r, 32'h0);
      chk("rst_tmo", tmo_pulse, 1'b0);
      chk("rst_s_adr_pass", s_adr, 32'h0000_1234);
      adv(); adv();
      rst = 1'b0;

      // Write to slave2 with two wait states
      adv();
      stb_seen = '0;
      m_dat_w = 32'hA5A5_0001;
      req(32'h0000_2004, 1'b1);
      settle();
      chk("a_idle_no_stb", s_stb, 4'h0);
      chk("a_s_dat_w", s_dat_w, 32'hA5A5_0001);
      chk("a_s_we", s_we, 1'b1);
      adv(); settle();
      chk("a_stb_w1", s_stb, 4'b0100);
      chk("a_cyc_w1", s_cyc, 4'b0100);
      chk("a_busy_w1", busy, 1'b1);
      chk("a_ack_w1", m_ack, 1'b0);
      adv(); settle();
      chk("a_stb_w2", s_stb, 4'b0100);
      chk("a_ack_w2", m_ack, 1'b0);
      adv(); s_ack = 4'b0100; settle();
      chk("a_ack", m_ack, 1'b1);
      chk("a_err", m_err, 1'b0);
      adv(); idle_bus(); settle();
      chk("a_ack_drop", m_ack, 1'b0);
      chk("a_busy_tail", busy, 1'b1);
      adv(); settle();
      chk("a_busy_idle", busy, 1'b0);
      chk("a_only_slave2", stb_seen, 4'b0100);

      // Unmapped read
      stb_seen = '0;
      req(32'h0000_9000, 1'b0);
      settle();
      chk("b_err_c1", m_err, 1'b0);
      adv(); settle();
      chk("b_err_c2", m_err, 1'b1);
      chk("b_ack_c2", m_ack, 1'b0);
      chk("b_busy_c2", busy, 1'b1);
      chk("b_dat_zero", m_dat_r, 32'h0);
      chk("b_tmo", tmo_pulse, 1'b0);
      adv(); idle_bus(); settle();
      chk("b_err_c3", m_err, 1'b0);
      chk("b_busy_c3", busy, 1'b0);
      chk("b_no_stb", stb_seen, 4'h0);

      // Timeout: slave2 never responds
      adv();
      req(32'h0000_2100, 1'b0);
      settle();
      for (int k = 1; k <= 8; k++) begin
         adv(); settle();
         chk("c_stb_wait", s_stb, 4'b0100);
         chk("c_tmo_wait", tmo_pulse, 1'b0);
      end
      adv(); settle();
      chk("c_stb_drop", s_stb, 4'h0);
      chk("c_cyc_drop", s_cyc, 4'h0);
      chk("c_err", m_err, 1'b1);
      chk("c_tmo", tmo_pulse, 1'b1);
      adv(); idle_bus(); settle();
      chk("c_tmo_once", tmo_pulse, 1'b0);
      chk("c_err_once", m_err, 1'b0);
      chk("c_idle", busy, 1'b0);

      // Response on the threshold cycle beats the timeout
      adv();
      req(32'h0000_2200, 1'b0);
      settle();
      for (int k = 1; k <= 8; k++) begin
         adv();
         if (k == 8) s_ack = 4'b0100;
         settle();
         chk("d_stb_wait", s_stb, 4'b0100);
      end
      chk("d_ack_thresh", m_ack, 1'b1);
      chk("d_dat", m_dat_r, 32'hCCCC_0002);
      adv(); idle_bus(); settle();
      chk("d_no_tmo", tmo_pulse, 1'b0);
      chk("d_no_err", m_err, 1'b0);
      chk("d_busy", busy, 1'b1);
      adv(); settle();
      chk("d_idle", busy, 1'b0);

      // Overlap: 0x900 goes to slave1, not slave3
      stb_seen = '0;
      req(32'h0000_0900, 1'b0);
      settle();
      adv(); s_ack = 4'b0010; settle();
      chk("e_stb_0900", s_stb, 4'b0010);
      chk("e_ack_0900", m_ack, 1'b1);
      chk("e_dat_0900", m_dat_r, 32'hBBBB_0001);
      adv(); idle_bus(); settle();
      adv(); settle();

      // Incrementing burst crossing 0x1000 stays locked on slave1
      acks = 0;
      m_cti = 3'b010;
      req(32'h0000_0FF8, 1'b0);
      settle();
      adv(); s_ack = 4'b0010; settle();
      chk("e_cti", s_cti, 3'b010);
      for (int b = 0; b < 4; b++) begin
         if (b > 0) begin
            adv();
            m_adr = 32'h0000_0FF8 + 32'(4 * b);
            if (b == 3) m_cti = 3'b111;
            settle();
         end
         chk("e_burst_stb", s_stb, 4'b0010);
         acks = acks + int'(m_ack);
      end
      chk("e_burst_acks", acks, 4);
      adv(); idle_bus(); settle();
      adv(); settle();
      chk("e_never_slave3", stb_seen, 4'b0010);

      // Slave drives ack and err together: only err forwarded
      req(32'h0000_3000, 1'b0);
      settle();
      adv(); s_ack = 4'b0001; s_err = 4'b0001; settle();
      chk("f_err", m_err, 1'b1);
      chk("f_ack", m_ack, 1'b0);
      adv(); idle_bus(); settle();
      adv(); settle();

      // Reset during a wait state, then a clean access to slave0
      req(32'h0000_3010, 1'b0);
      settle();
      adv(); settle();
      adv(); settle();
      adv(); settle();
      chk("g_stb_before", s_stb, 4'b0001);
      rst = 1'b1;
      #1;
      chk("g_stb_rst", s_stb, 4'h0);
      chk("g_cyc_rst", s_cyc, 4'h0);
      chk("g_busy_rst", busy, 1'b0);
      idle_bus();
      adv();
      rst = 1'b0;
      settle();
      chk("g_no_ack", m_ack, 1'b0);
      chk("g_no_err", m_err, 1'b0);
      req(32'h0000_3010, 1'b0);
      settle();
      chk("g_idle_req", busy, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         adv();
         if (k == 8) s_ack = 4'b0001;
         settle();
         chk("g_stb_wait", s_stb, 4'b0001);
         chk("g_tmo_wait", tmo_pulse, 1'b0);
      end
      chk("g_ack", m_ack, 1'b1);
      chk("g_dat", m_dat_r, 32'hAAAA_0000);
      adv(); idle_bus(); settle();
      chk("g_no_tmo", tmo_pulse, 1'b0);
      adv(); settle();
      chk("g_idle", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
